// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decode-state encoding and parity helper
// for the PS/2 keyboard decoder.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// Bit-level PS/2 receiver: synchronizes the bus, samples data on falling
// clock edges, assembles 11-bit frames and flags parity/stop/timeout errors.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] timer;

    // Two-stage synchronizers (idle-high on reset) plus a delayed copy of the clock for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    // Frame assembly: start, 8 data bits LSB-first, odd parity, stop; abort on inter-edge timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            timer      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;
            if (fall) begin
                timer <= '0;
                if (bit_cnt == 4'd0) begin
                    // a high start bit is noise; stay waiting for a real start
                    if (!dat_s2)
                        bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shift   <= {dat_s2, shift[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    par_bit <= dat_s2;
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= '0;
                    if (parity_ok(shift, par_bit) && dat_s2) begin
                        byte_data  <= shift;
                        byte_valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (bit_cnt != 4'd0) begin
                if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt <= '0;
                    timer   <= '0;
                    err     <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: turns received scan codes into held-key levels
// for space, left arrow and right arrow.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_space,
    output logic       key_left,
    output logic       key_right,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    dec_state_t state;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_data (rx_byte),
        .byte_valid(rx_valid),
        .err       (rx_err)
    );

    assign scan_code  = rx_byte;
    assign scan_valid = rx_valid;
    assign frame_err  = rx_err;

    // Make/break sequence decoder; advances only on good bytes, so frame errors leave it untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            key_space <= 1'b0;
            key_left  <= 1'b0;
            key_right <= 1'b0;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_byte == SC_EXT)
                        state <= ST_EXT;
                    else if (rx_byte == SC_BRK)
                        state <= ST_BRK;
                    else begin
                        state <= ST_IDLE;
                        if (rx_byte == SC_SPACE)
                            key_space <= 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_byte == SC_BRK)
                        state <= ST_EXT_BRK;
                    else if (rx_byte == SC_EXT)
                        state <= ST_EXT;
                    else begin
                        state <= ST_IDLE;
                        if (rx_byte == SC_LEFT)
                            key_left <= 1'b1;
                        else if (rx_byte == SC_RIGHT)
                            key_right <= 1'b1;
                    end
                end
                ST_BRK: begin
                    if (rx_byte == SC_BRK)
                        state <= ST_BRK;
                    else begin
                        state <= ST_IDLE;
                        if (rx_byte == SC_SPACE)
                            key_space <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (rx_byte == SC_LEFT)
                        key_left <= 1'b0;
                    else if (rx_byte == SC_RIGHT)
                        key_right <= 1'b0;
                end
            endcase
        end
    end

endmodule
